// File: rtl/bus_mem_io_slave_if.sv
// Local-bus signal bundle between the CPU-side master (address latch/strobes)
// and the memory/I/O slave.
interface bus_mem_io_slave_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              ALE;
    logic              IOM;
    logic              RD_N;
    logic              WR_N;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W-1:0] RDATA;
    logic              RDATA_VALID;
    logic              READY;
    logic              BUSY;
    logic              ERR;

    modport master (
        output ALE, IOM, RD_N, WR_N, ADDR, WDATA,
        input  RDATA, RDATA_VALID, READY, BUSY, ERR
    );

    modport slave (
        input  ALE, IOM, RD_N, WR_N, ADDR, WDATA,
        output RDATA, RDATA_VALID, READY, BUSY, ERR
    );
endinterface

// File: rtl/bus_mem_io_slave.sv
// 8086-style local-bus slave: ALE-latched cycle, programmable wait states,
// separate memory array and resettable I/O register file, range/protocol errors.
module bus_mem_io_slave #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 8,
    parameter int MEM_AW      = 16,
    parameter int IO_AW       = 8,
    parameter int WAIT_STATES = 1
) (
    input logic                 CLK,
    input logic                 RESET,
    bus_mem_io_slave_if.slave   bus
);
    localparam int MEM_WORDS = 1 << MEM_AW;
    localparam int IO_WORDS  = 1 << IO_AW;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              is_io_reg;
    logic              is_wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              err_reg;

    logic [DATA_W-1:0] mem_array [MEM_WORDS];
    logic [DATA_W-1:0] io_regs   [IO_WORDS];

    logic              strobe_ok;
    logic              mem_ok;
    logic              io_ok;
    logic              in_range;
    logic              do_write;
    logic [MEM_AW-1:0] mem_idx;
    logic [IO_AW-1:0]  io_idx;

    // Exactly one strobe low makes a legal cycle.
    assign strobe_ok = bus.RD_N ^ bus.WR_N;
    assign mem_idx   = addr_reg[MEM_AW-1:0];
    assign io_idx    = addr_reg[IO_AW-1:0];
    assign mem_ok    = (addr_reg >> MEM_AW) == '0;
    assign io_ok     = (addr_reg >> IO_AW) == '0;
    assign in_range  = is_io_reg ? io_ok : mem_ok;
    assign do_write  = (state_reg == ST_ACCESS) && is_wr_reg && in_range;

    always_ff @(posedge CLK) begin
        if (!RESET && do_write && !is_io_reg)
            mem_array[mem_idx] <= wdata_reg;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < IO_WORDS; i++)
                io_regs[i] <= '0;
        end else if (do_write && is_io_reg) begin
            io_regs[io_idx] <= wdata_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            is_io_reg  <= 1'b0;
            is_wr_reg  <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.ALE) begin
                        if (strobe_ok) begin
                            is_io_reg <= bus.IOM;
                            is_wr_reg <= ~bus.WR_N;
                            addr_reg  <= bus.ADDR;
                            wdata_reg <= bus.WDATA;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= 4'd0;
                            if (WAIT_STATES > 0) begin
                                state_reg <= ST_WAIT;
                                ready_reg <= 1'b0;
                            end else begin
                                state_reg <= ST_ACCESS;
                            end
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == WAIT_LAST) begin
                        state_reg <= ST_ACCESS;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    err_reg   <= ~in_range;
                    if (!is_wr_reg) begin
                        // Out-of-range reads still complete, returning all ones.
                        rvalid_reg <= 1'b1;
                        if (!in_range)
                            rdata_reg <= '1;
                        else if (is_io_reg)
                            rdata_reg <= io_regs[io_idx];
                        else
                            rdata_reg <= mem_array[mem_idx];
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RDATA       = rdata_reg;
    assign bus.RDATA_VALID = rvalid_reg;
    assign bus.READY       = ready_reg;
    assign bus.BUSY        = busy_reg;
    assign bus.ERR         = err_reg;
endmodule
